retire_trace_buffer: RTL

//  On-chip trace capture for the RISC-V core. It records retired-instruction tuples
//  (PC, instruction, ALU result) into a circular buffer while armed. It freezes a

---
 rtl/retire_trace_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: circular capture of retired {pc,instr,alu} tuples with trigger freeze and oldest-first readback
module retire_trace_buffer #(
   parameter int XLEN = 32,
   parameter int DEPTH = 16,
   parameter int POST_TRIG = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            arm_i,
   input  logic            trig_i,
   input  logic            trig_pc_en_i,
   input  logic [XLEN-1:0] trig_pc_i,
   input  logic            ret_valid_i,
   input  logic [XLEN-1:0] ret_pc_i,
   input  logic [31:0]     ret_instr_i,
   input  logic [XLEN-1:0] ret_alu_i,
   input  logic            rd_en_i,
   input  logic [AW-1:0]   rd_idx_i,
   output logic            rd_valid_o,
   output logic [XLEN-1:0] rd_pc_o,
   output logic [31:0]     rd_instr_o,
   output logic [XLEN-1:0] rd_alu_o,
   output logic [1:0]      state_o,
   output logic [AW:0]     count_o,
   output logic [AW-1:0]   trig_idx_o,
   output logic            done_o
);
   typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_e;
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] PT1 = (AW+1)'(POST_TRIG + 1);
   state_e state_q, state_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, oldest, addr;
   logic [AW:0] count_q, count_d, post_q, post_d, trig_off;
   logic done_q, we, trig, hit, rd_ok;
   logic rd_valid_q, rd_valid_d;
   logic [XLEN-1:0] rd_pc_q, rd_pc_d, rd_alu_q, rd_alu_d;
   logic [31:0] rd_instr_q, rd_instr_d;
   logic [XLEN-1:0] mem_pc [DEPTH];
   logic [31:0] mem_instr [DEPTH];
   logic [XLEN-1:0] mem_alu [DEPTH];
   assign we = !arm_i && ret_valid_i && (state_q == ARMED || state_q == POST);
   assign trig = trig_i || (trig_pc_en_i && ret_valid_i && ret_pc_i == trig_pc_i);
   // Once full, the write pointer sits on the oldest entry
   assign oldest = (count_q == FULL) ? wr_ptr_q : '0;
   assign addr = oldest + rd_idx_i;
   assign hit = {1'b0, rd_idx_i} < count_q;
   assign rd_ok = rd_en_i && state_q == DONE;
   always_comb begin
      state_d = state_q;
      post_d = post_q;
      wr_ptr_d = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
      count_d = (we && count_q != FULL) ? count_q + (AW+1)'(1) : count_q;
      if (arm_i) begin
         state_d = ARMED;
         wr_ptr_d = '0;
         count_d = '0;
      end else if (state_q == ARMED && trig) begin
         post_d = PT1 - (AW+1)'(ret_valid_i);
         state_d = (post_d == '0) ? DONE : POST;
      end else if (state_q == POST && ret_valid_i) begin
         post_d = post_q - (AW+1)'(1);
         state_d = (post_d == '0) ? DONE : POST;
      end
   end
   always_comb begin
      rd_valid_d = rd_ok;
      rd_pc_d = rd_en_i ? ((rd_ok && hit) ? mem_pc[addr] : '0) : rd_pc_q;
      rd_instr_d = rd_en_i ? ((rd_ok && hit) ? mem_instr[addr] : '0) : rd_instr_q;
      rd_alu_d = rd_en_i ? ((rd_ok && hit) ? mem_alu[addr] : '0) : rd_alu_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wr_ptr_q <= '0;
         count_q <= '0;
         post_q <= '0;
         done_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_pc_q <= '0;
         rd_instr_q <= '0;
         rd_alu_q <= '0;
      end else begin
         state_q <= state_d;
         wr_ptr_q <= wr_ptr_d;
         count_q <= count_d;
         post_q <= post_d;
         done_q <= state_d == DONE;
         rd_valid_q <= rd_valid_d;
         rd_pc_q <= rd_pc_d;
         rd_instr_q <= rd_instr_d;
         rd_alu_q <= rd_alu_d;
      end
   end
   always_ff @(posedge clk) begin
      if (we) begin
         mem_pc[wr_ptr_q] <= ret_pc_i;
         mem_instr[wr_ptr_q] <= ret_instr_i;
         mem_alu[wr_ptr_q] <= ret_alu_i;
      end
   end
   assign trig_off = count_q - PT1;
   assign trig_idx_o = (state_q == DONE) ? trig_off[AW-1:0] : '0;
   assign state_o = state_q;
   assign count_o = count_q;
   assign done_o = done_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_pc_o = rd_pc_q;
   assign rd_instr_o = rd_instr_q;
   assign rd_alu_o = rd_alu_q;
endmodule
